// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline boundary.
// Pairs each synchronous instruction-memory read word with the fetch address
// that produced it and registers the pair, with a valid bit, toward decode.
// A 1-entry skid buffer absorbs the single in-flight fetch when ID stalls,
// and flush turns everything fetched-but-undecoded into bubbles.
// Optional build macro IF_ID_PERF_CNT_EN adds stall/flush counters and a
// simulation-only mutual-exclusion check on the response and skid valids.

`ifdef IF_ID_PERF_CNT_EN
// Simulation-only checker: a response can never land while the skid is full,
// because the fetch that would produce it was held by if_stall.
module if_id_stage_chk (
    input logic cpu_clk_50M,
    input logic cpu_rst_n,
    input logic rsp_v,
    input logic skid_v
);

    a_rsp_skid_excl: assert property (@(posedge cpu_clk_50M) disable iff (!cpu_rst_n)
        !(rsp_v && skid_v));

endmodule
`endif

module if_id_stage #(
    parameter int unsigned      ADDR_W   = 32,
    parameter int unsigned      INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0000
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              if_ce,
    input  logic [INST_W-1:0] im_inst,
    input  logic              id_stall,
    input  logic              flush,
    output logic              if_stall,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_valid
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
`endif
);

    typedef enum logic [0:0] {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_e;

    // Response tracking: which address the current im_inst belongs to.
    logic [ADDR_W-1:0] rsp_pc_r;
    logic              rsp_v_r;
    logic [ADDR_W-1:0] rsp_pc_s;
    logic              rsp_v_s;

    // Skid buffer.
    skid_state_e       skid_state_r;
    skid_state_e       skid_state_s;
    logic [ADDR_W-1:0] skid_pc_r;
    logic [INST_W-1:0] skid_inst_r;
    logic [ADDR_W-1:0] skid_pc_s;
    logic [INST_W-1:0] skid_inst_s;
    logic              skid_v_s;

    // ID-facing registers.
    logic [ADDR_W-1:0] id_pc_r;
    logic [INST_W-1:0] id_inst_r;
    logic              id_valid_r;
    logic [ADDR_W-1:0] id_pc_s;
    logic [INST_W-1:0] id_inst_s;
    logic              id_valid_s;

    // IF must hold its address in the very cycle decode refuses an instruction.
    assign if_stall = id_stall;
    assign skid_v_s = (skid_state_r == SKID_FULL);

    assign id_pc    = id_pc_r;
    assign id_inst  = id_inst_r;
    assign id_valid = id_valid_r;

    // State register for response tracking, skid FSM and ID outputs.
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            rsp_pc_r     <= {ADDR_W{1'b0}};
            rsp_v_r      <= 1'b0;
            skid_state_r <= SKID_EMPTY;
            skid_pc_r    <= {ADDR_W{1'b0}};
            skid_inst_r  <= NOP_INST;
            id_pc_r      <= {ADDR_W{1'b0}};
            id_inst_r    <= NOP_INST;
            id_valid_r   <= 1'b0;
        end else begin
            rsp_pc_r     <= rsp_pc_s;
            rsp_v_r      <= rsp_v_s;
            skid_state_r <= skid_state_s;
            skid_pc_r    <= skid_pc_s;
            skid_inst_r  <= skid_inst_s;
            id_pc_r      <= id_pc_s;
            id_inst_r    <= id_inst_s;
            id_valid_r   <= id_valid_s;
        end
    end

    // Next-state: flush beats stall, stall beats skid drain, else pass-through.
    always_comb begin
        rsp_pc_s     = if_pc;
        rsp_v_s      = if_ce & ~if_stall & ~flush;
        skid_state_s = skid_state_r;
        skid_pc_s    = skid_pc_r;
        skid_inst_s  = skid_inst_r;
        id_pc_s      = id_pc_r;
        id_inst_s    = id_inst_r;
        id_valid_s   = id_valid_r;

        if (flush) begin
            // Drop everything in flight; id_pc keeps its last value.
            id_valid_s   = 1'b0;
            id_inst_s    = NOP_INST;
            skid_state_s = SKID_EMPTY;
        end else if (id_stall) begin
            // ID holds; park the one in-flight response if it arrives now.
            case (skid_state_r)
                SKID_EMPTY: begin
                    if (rsp_v_r) begin
                        skid_pc_s    = rsp_pc_r;
                        skid_inst_s  = im_inst;
                        skid_state_s = SKID_FULL;
                    end else begin
                        skid_state_s = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    skid_state_s = SKID_FULL;
                end
                default: begin
                    skid_state_s = SKID_EMPTY;
                end
            endcase
        end else begin
            case (skid_state_r)
                SKID_FULL: begin
                    // Parked instruction goes first; no new response exists yet.
                    id_pc_s      = skid_pc_r;
                    id_inst_s    = skid_inst_r;
                    id_valid_s   = 1'b1;
                    skid_state_s = SKID_EMPTY;
                end
                SKID_EMPTY: begin
                    if (rsp_v_r) begin
                        id_pc_s    = rsp_pc_r;
                        id_inst_s  = im_inst;
                        id_valid_s = 1'b1;
                    end else begin
                        id_valid_s = 1'b0;
                        id_inst_s  = NOP_INST;
                    end
                end
                default: begin
                    skid_state_s = SKID_EMPTY;
                    id_valid_s   = 1'b0;
                    id_inst_s    = NOP_INST;
                end
            endcase
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] flush_count_r;

    assign stall_cycles = stall_cycles_r;
    assign flush_count  = flush_count_r;

    // Free-running wrap-around counters of stalled and flushed edges.
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            stall_cycles_r <= 32'd0;
            flush_count_r  <= 32'd0;
        end else begin
            if (id_stall && !flush) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end
            if (flush) begin
                flush_count_r <= flush_count_r + 32'd1;
            end
        end
    end

    if_id_stage_chk u_chk (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst_n   (cpu_rst_n),
        .rsp_v       (rsp_v_r),
        .skid_v      (skid_v_s)
    );
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: scoreboard bench for if_id_stage. The bench plays the IF
// stage and a synchronous instruction memory (word = 0x1000 + address).
// Every accepted fetch is pushed to a queue; each decode-accepting edge pops
// the oldest fetch that already has its memory response, or expects a bubble.

module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } item_t;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst_n   = 1'b0;
    logic [31:0] if_pc       = 32'd0;
    logic        if_ce       = 1'b0;
    logic [31:0] im_inst     = 32'd0;
    logic        id_stall    = 1'b0;
    logic        flush       = 1'b0;
    logic        if_stall;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    int checks = 0;
    int errors = 0;

    item_t       sb_q[$];
    logic [31:0] cur_pc    = 32'd0;
    logic [31:0] prev_pc   = 32'd0;
    logic        prev_ce   = 1'b0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_pc    = 32'd0;
    logic [31:0] exp_inst  = 32'd0;
    int          n_stall   = 0;
    int          n_flush   = 0;

    if_id_stage dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst_n   (cpu_rst_n),
        .if_pc       (if_pc),
        .if_ce       (if_ce),
        .im_inst     (im_inst),
        .id_stall    (id_stall),
        .flush       (flush),
        .if_stall    (if_stall),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_valid    (id_valid)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`endif
    );

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    function automatic logic [31:0] im_word(input logic [31:0] a);
        return 32'h0000_1000 + a;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_val("id_valid", 64'(id_valid), 64'(exp_valid));
        check_val("id_pc",    64'(id_pc),    64'(exp_pc));
        check_val("id_inst",  64'(id_inst),  64'(exp_inst));
    endtask

    // One reset cycle; stall is driven to show if_stall tracks it in reset.
    task automatic rst_cyc(input logic stall);
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b0;
        if_ce     = 1'b0;
        id_stall  = stall;
        flush     = 1'b0;
        im_inst   = 32'hDEAD_BEEF;
        prev_ce   = 1'b0;
        #1;
        check_val("if_stall_rst", 64'(if_stall), 64'(stall));
        sb_q.delete();
        exp_valid = 1'b0;
        exp_pc    = 32'd0;
        exp_inst  = NOP;
        n_stall   = 0;
        n_flush   = 0;
        @(posedge cpu_clk_50M);
        #1;
        check_outputs();
    endtask

    // One operating cycle acting as IF; redir is the flush target address.
    task automatic cyc(input logic ce, input logic stall, input logic fl,
                       input logic [31:0] redir);
        item_t it;
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        im_inst   = prev_ce ? im_word(prev_pc) : 32'hDEAD_BEEF;
        if_pc     = cur_pc;
        if_ce     = ce;
        id_stall  = stall;
        flush     = fl;
        prev_pc   = cur_pc;
        prev_ce   = ce;
        #1;
        check_val("if_stall", 64'(if_stall), 64'(stall));
        if (fl) begin
            sb_q.delete();
            exp_valid = 1'b0;
            exp_inst  = NOP;
            n_flush++;
        end else if (stall) begin
            n_stall++;
        end else if (sb_q.size() > 0) begin
            it        = sb_q.pop_front();
            exp_valid = 1'b1;
            exp_pc    = it.pc;
            exp_inst  = it.inst;
        end else begin
            exp_valid = 1'b0;
            exp_inst  = NOP;
        end
        if (ce && !stall && !fl) begin
            it.pc   = cur_pc;
            it.inst = im_word(cur_pc);
            sb_q.push_back(it);
        end
        @(posedge cpu_clk_50M);
        #1;
        check_outputs();
        if (fl) begin
            cur_pc = redir;
        end else if (ce && !stall) begin
            cur_pc = cur_pc + 32'd1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic stall_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    endtask

    initial begin
        // Reset, with id_stall toggled to observe if_stall in reset.
        rst_cyc(1'b1);
        rst_cyc(1'b0);

        // Streaming from 0, then a single-cycle stall while id_pc=1.
        cur_pc = 32'd0;
        run(3);
        stall_n(1);
        run(4);

        // Long stall; skid holds the in-flight word across all 5 cycles.
        stall_n(5);
        run(3);

        // Flush while stalled with the skid full, redirect to 0x40.
        stall_n(2);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        run(4);

        // Flush and stall together while a response is landing (skid empty).
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0080);
        run(3);

        // Two-cycle fetch gap produces two bubbles.
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        run(4);

        // Plain flush while streaming, redirect to 0xC0.
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_00C0);
        run(4);

`ifdef IF_ID_PERF_CNT_EN
        check_val("stall_cycles", 64'(stall_cycles), 64'(n_stall));
        check_val("flush_count",  64'(flush_count),  64'(n_flush));
`endif

        // Reset in the middle of a stall with the skid full.
        stall_n(2);
        rst_cyc(1'b1);
        cur_pc = 32'h0000_0100;
        run(4);
        stall_n(1);
        run(3);

`ifdef IF_ID_PERF_CNT_EN
        check_val("stall_cycles_post_rst", 64'(stall_cycles), 64'(n_stall));
        check_val("flush_count_post_rst",  64'(flush_count),  64'(n_flush));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Pipeline boundary between instruction fetch and decode.
- Pairs each synchronous instruction-memory read word with the fetch address that produced it.
- Registers the pair, with a valid bit, toward ID.
- Absorbs the one in-flight fetch when ID stalls, using a 1-entry skid buffer, and inserts bubbles on flush.

Parameters:
- ADDR_W, 32, width of fetch address (im_addr_t width, word address).
- INST_W, 32, instruction word width.
- NOP_INST, 32'h0000_0000, instruction driven on bubbles (sll $0,$0,0).

Ports:
- cpu_clk_50M  in  1  system clock; all state updates on posedge.
- cpu_rst_n  in  1  reset; one clock, synchronous, active-low.
- if_pc  in  ADDR_W  address currently presented to IM (imaddr).
- if_ce  in  1  IM chip enable (imce).
- im_inst  in  INST_W  IM read data; valid the cycle after its address was presented with if_ce=1.
- id_stall  in  1  decode cannot accept a new instruction this cycle.
- flush  in  1  discard all fetched-but-undecoded instructions (branch/jump redirect).
- if_stall  out  1  hold request to IF (hold imaddr).
- id_pc  out  ADDR_W  address of instruction in ID.
- id_inst  out  INST_W  instruction in ID.
- id_valid  out  1  id_pc/id_inst hold a real instruction.

Behaviour:
- Reset (cpu_rst_n=0 at posedge):
  - id_valid=0, id_inst=NOP_INST, id_pc=0.
  - rsp_v=0, skid_v=0.
  - if_stall follows id_stall combinationally even during reset.
- Response tracking register, every edge:
  - rsp_pc <= if_pc.
  - rsp_v <= if_ce & ~if_stall & ~flush.
  - During a cycle, rsp_v=1 means im_inst is the word for rsp_pc.
  - A held address re-presented during stall produces no response. It is fetched exactly once, in the first non-stalled cycle.
- if_stall = id_stall (combinational, zero latency).
- Skid buffer: regs skid_pc, skid_inst, skid_v. It is a two-state FSM, EMPTY (skid_v=0) and FULL (skid_v=1).
- Edge update rules, in priority order:
  1. flush=1: id_valid<=0, id_inst<=NOP_INST, skid_v<=0. id_pc is unchanged. flush overrides id_stall.
  2. id_stall=1:
     - ID regs hold.
     - If EMPTY and rsp_v=1: skid captures (rsp_pc, im_inst) and the FSM goes to FULL.
     - If FULL: hold.
     - rsp_v=1 while FULL is impossible by construction; the optional assertion checks it.
  3. id_stall=0, FULL: ID regs <= skid contents, id_valid<=1, FSM goes to EMPTY. rsp_v is 0 in this cycle by construction.
  4. id_stall=0, EMPTY:
     - rsp_v=1: id_pc<=rsp_pc, id_inst<=im_inst, id_valid<=1.
     - rsp_v=0: id_valid<=0, id_inst<=NOP_INST.
- Latency: address on if_pc in cycle n (no stall/flush) appears on id_* in cycle n+2.
- Throughput: 1 instruction/cycle.
- No instruction is lost or duplicated across any stall length ≥1.
- flush in the same cycle as skid capture: flush wins and the skid stays empty.
- Reset mid-stall: all valid bits clear, the FSM goes to EMPTY, and in-flight data is dropped.
- No arithmetic; widths are passed through unmodified.

Optional Feature:
- Macro IF_ID_PERF_CNT_EN.
- Defined:
  - Extra outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments each edge with id_stall=1 & ~flush.
  - flush_count increments each edge with flush=1.
  - Both wrap at 2^32 and reset to 0.
  - Adds a simulation-only check that rsp_v & skid_v never both equal 1.
- Undefined: ports and logic are absent; core behaviour is identical.

Test Plan:
- Reset then streaming:
  - Stimulus: cpu_rst_n low 2 cycles, then if_pc=0,1,2,3 with if_ce=1, IM returning 0x1000+addr.
  - Expected: id_valid first high 2 cycles after if_pc=0, with id_pc/id_inst = 0/0x1000, 1/0x1001, 2/0x1002 on consecutive cycles.
- Single-cycle stall:
  - Stimulus: stream as above; id_stall=1 for one cycle while id_pc=1.
  - Expected: id_pc holds 1 for 2 cycles, then 2, 3, ... with no gap, no repeat and no loss.
- Long stall (5 cycles) during streaming:
  - Expected: skid_v=1 from the first stall cycle; if_stall=1 for 5 cycles.
  - Expected after release: id_pc sequence continues +1 with no duplicate of the held address.
- Flush during stall with skid full:
  - Stimulus: assert flush for 1 cycle; IF then redirects to 0x40.
  - Expected: id_valid=0 and id_inst=0 next cycle, skid empty; next valid id_pc=0x40, two cycles after 0x40 is on if_pc.
- Flush and stall simultaneously:
  - Expected: flush wins; id_valid=0, and nothing is captured into the skid.
- if_ce=0 gap:
  - Stimulus: if_ce low for 2 cycles mid-stream.
  - Expected: 2 bubble cycles (id_valid=0, id_inst=0); id_pc is unchanged during bubbles.
  - With IF_ID_PERF_CNT_EN: stall_cycles and flush_count match injected counts.
